q_sweep_sequencer: RTL and testbench
====================================

// Module: q_sweep_sequencer
// PURPOSE
//  Sequences the Q control loop (top) through a programmable table of q_desired setpoints.
//  Per step: drives a reset pulse to the loop, applies the setpoint, waits for a deglitched
//  'converged' or a timeout, records the outcome, then advances. Sits between the host/bench
//  and top's q_desired/rst/start/enable inputs, replacing hand-written sweep stimulus.
// PARAMETERS
//  BUS_WIDTH      10     width of setpoints and q_desired
//  N_SETPOINTS    4      table depth (>=1); index width IW=$clog2(N_SETPOINTS) (min 1)
//  MAX_TIMEOUT    50000  cycles in TRACK before a step is declared timed out (>=1)
//  RST_CYCLES     5      length of each loop_rst pulse, in cycles (>=1)
//  CONFIRM_CYCLES 3      consecutive converged-high cycles required to accept a step (>=1)
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous, active-low reset
//  go           in   1          start sweep (sampled in IDLE only)
//  abort        in   1          terminate sweep, any state
//  sp_wr_en     in   1          setpoint table write strobe
//  sp_wr_addr   in   IW         table write address
//  sp_wr_data   in   BUS_WIDTH  table write data
//  converged    in   1          from q_control converged flag
//  q_desired    out  BUS_WIDTH  setpoint to loop
//  loop_rst     out  1          active-high reset to loop
//  loop_start   out  1          loop start
//  loop_enable  out  1          loop enable
//  busy         out  1          sweep in progress
//  step_idx     out  IW         current table index
//  step_ok      out  1          1-cycle pulse: step converged
//  step_timeout out  1          1-cycle pulse: step timed out
//  fail_count   out  IW+1       timed-out steps this sweep, saturating
//  done         out  1          1-cycle pulse: sweep completed normally
// BEHAVIOUR
//  Reset (rst=0): state IDLE; all outputs 0; table entries 0; timers/counters 0.
//  States: IDLE, INIT_RST, ARM, TRACK, STEP_RST, DONE.
//  IDLE: go=1 -> INIT_RST; step_idx<=0, fail_count<=0, busy<=1 next cycle.
//  INIT_RST: loop_rst=1 for exactly RST_CYCLES cycles -> ARM.
//  ARM (1 cycle): q_desired<=table[step_idx]; loop_start<=1, loop_enable<=1 (held until
//   DONE/abort); timer<=0; confirm<=0 -> TRACK. q_desired held constant until next ARM.
//  TRACK: timer+1/cycle; confirm+1 while converged=1, cleared to 0 when converged=0.
//   confirm reaches CONFIRM_CYCLES -> step_ok pulse, -> STEP_RST.
//   else timer reaches MAX_TIMEOUT -> step_timeout pulse, fail_count+1 (saturate), -> STEP_RST.
//   Both in same cycle: step_ok wins, no timeout, no fail increment.
//  STEP_RST: loop_rst=1 for RST_CYCLES cycles; converged ignored. Then:
//   step_idx==N_SETPOINTS-1 -> DONE; else step_idx+1 -> ARM.
//  DONE (1 cycle): done=1; busy, loop_start, loop_enable <=0 -> IDLE. q_desired keeps last value.
//  abort=1 in any non-IDLE state: next cycle IDLE; busy/loop_start/loop_enable/loop_rst=0;
//   no done/step_ok/step_timeout pulse; fail_count, step_idx frozen for inspection.
//   abort and go together in IDLE: abort wins, stay IDLE.
//  Table writes: accepted only when busy=0 and state IDLE; ignored otherwise; sp_wr_addr
//   >= N_SETPOINTS ignored. Write and go in same cycle: write lands, sweep uses new value.
//  go while busy ignored. Async reset mid-sweep: immediate return to reset values.
//  All outputs registered; no combinational path input->output.
// CONFIGURATION
//  Macro Q_SWEEP_LOG_EN. Defined: extra outputs log_valid (1), log_cycles
//   ($clog2(MAX_TIMEOUT+1)) and log_idx (IW); on each step_ok/step_timeout cycle log_valid=1,
//   log_cycles=TRACK cycles consumed (timer value), log_idx=step_idx; 0 otherwise, reset 0.
//  Not defined: ports and logging logic absent; all other behaviour identical.
// TESTING
//  1 Table {40,60,80,100}, go, converged rises 10 cycles after each ARM -> q_desired steps
//    40,60,80,100; 4 step_ok pulses; fail_count=0; done once; busy low after DONE.
//  2 converged never asserts, MAX_TIMEOUT=20 -> 4 step_timeout each 20 TRACK cycles after ARM;
//    fail_count=4; done pulses.
//  3 converged glitches 1,1,0,1,1,1 (CONFIRM_CYCLES=3) -> step_ok only after third
//    consecutive high; converged held high during STEP_RST produces no extra step_ok.
//  4 abort in TRACK of step 2 -> next cycle busy=0, loop_enable=0, no done; step_idx=2 frozen;
//    new go restarts from idx 0 with fail_count=0.
//  5 sp_wr_en during sweep (addr 0, data 999) -> ignored, table[0] unchanged next sweep;
//    rst=0 mid-STEP_RST -> all outputs 0 immediately.
//  6 Q_SWEEP_LOG_EN: converged at TRACK cycle 7, CONFIRM_CYCLES=3 -> log_valid with log_cycles
//    matching step_ok cycle, log_idx=step_idx.

Source files
------------

// File: rtl/q_sweep_sequencer.sv
// q_sweep_sequencer: steps the Q control loop through a programmable table of
// q_desired setpoints. For each step it pulses loop_rst, applies the setpoint,
// then waits until 'converged' has been high for CONFIRM_CYCLES consecutive
// cycles or the step times out. It reports the outcome and moves to the next entry.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   go, abort            start sweep (IDLE only) / terminate sweep (any state)
//   sp_wr_en/addr/data   setpoint table write port (IDLE and not busy only)
//   converged            convergence flag from the loop
//   q_desired            setpoint driven to the loop
//   loop_rst/start/enable  loop control
//   busy, step_idx       sweep in progress, current table index
//   step_ok/step_timeout one-cycle step outcome pulses
//   fail_count           timed-out steps in this sweep (saturating)
//   done                 one-cycle pulse when a sweep completes normally
//
// Optional feature: define Q_SWEEP_LOG_EN to add log_valid/log_cycles/log_idx,
// which report the TRACK cycles consumed and the index of each finished step.
module q_sweep_sequencer #(
  parameter int unsigned BUS_WIDTH      = 10,
  parameter int unsigned N_SETPOINTS    = 4,
  parameter int unsigned MAX_TIMEOUT    = 50000,
  parameter int unsigned RST_CYCLES     = 5,
  parameter int unsigned CONFIRM_CYCLES = 3,
  localparam int unsigned IW = (N_SETPOINTS > 1) ? $clog2(N_SETPOINTS) : 1,
  localparam int unsigned TW = $clog2(MAX_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 abort,
  input  logic                 sp_wr_en,
  input  logic [IW-1:0]        sp_wr_addr,
  input  logic [BUS_WIDTH-1:0] sp_wr_data,
  input  logic                 converged,
  output logic [BUS_WIDTH-1:0] q_desired,
  output logic                 loop_rst,
  output logic                 loop_start,
  output logic                 loop_enable,
  output logic                 busy,
  output logic [IW-1:0]        step_idx,
  output logic                 step_ok,
  output logic                 step_timeout,
  output logic [IW:0]          fail_count,
`ifdef Q_SWEEP_LOG_EN
  output logic                 log_valid,
  output logic [TW-1:0]        log_cycles,
  output logic [IW-1:0]        log_idx,
`endif
  output logic                 done
);

  localparam int unsigned FW = IW + 1;
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned CW = $clog2(CONFIRM_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT_RST = 3'd1,
    S_ARM      = 3'd2,
    S_TRACK    = 3'd3,
    S_STEP_RST = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        confirm_q, confirm_d;
  logic [BUS_WIDTH-1:0] q_desired_q, q_desired_d;
  logic                 loop_rst_q, loop_rst_d;
  logic                 loop_start_q, loop_start_d;
  logic                 loop_enable_q, loop_enable_d;
  logic                 busy_q, busy_d;
  logic [IW-1:0]        step_idx_q, step_idx_d;
  logic                 step_ok_q, step_ok_d;
  logic                 step_timeout_q, step_timeout_d;
  logic [FW-1:0]        fail_count_q, fail_count_d;
  logic                 done_q, done_d;
`ifdef Q_SWEEP_LOG_EN
  logic                 log_valid_q, log_valid_d;
  logic [TW-1:0]        log_cycles_q, log_cycles_d;
  logic [IW-1:0]        log_idx_q, log_idx_d;
`endif

  logic [BUS_WIDTH-1:0] sp_table_q [N_SETPOINTS];
  logic                 addr_in_range;
  logic                 table_wr;

  // A power-of-two table makes every address legal; otherwise the top codes are dropped.
  if (N_SETPOINTS == (32'd1 << IW)) begin : g_addr_full
    assign addr_in_range = 1'b1;
  end else begin : g_addr_part
    assign addr_in_range = ({1'b0, sp_wr_addr} < FW'(N_SETPOINTS));
  end

  assign table_wr = sp_wr_en && !busy_q && (state_q == S_IDLE) && addr_in_range;

  // Setpoint table storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_SETPOINTS; i++) begin
        sp_table_q[i] <= '0;
      end
    end else if (table_wr) begin
      sp_table_q[sp_wr_addr] <= sp_wr_data;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      rst_cnt_q      <= '0;
      timer_q        <= '0;
      confirm_q      <= '0;
      q_desired_q    <= '0;
      loop_rst_q     <= 1'b0;
      loop_start_q   <= 1'b0;
      loop_enable_q  <= 1'b0;
      busy_q         <= 1'b0;
      step_idx_q     <= '0;
      step_ok_q      <= 1'b0;
      step_timeout_q <= 1'b0;
      fail_count_q   <= '0;
      done_q         <= 1'b0;
`ifdef Q_SWEEP_LOG_EN
      log_valid_q    <= 1'b0;
      log_cycles_q   <= '0;
      log_idx_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      timer_q        <= timer_d;
      confirm_q      <= confirm_d;
      q_desired_q    <= q_desired_d;
      loop_rst_q     <= loop_rst_d;
      loop_start_q   <= loop_start_d;
      loop_enable_q  <= loop_enable_d;
      busy_q         <= busy_d;
      step_idx_q     <= step_idx_d;
      step_ok_q      <= step_ok_d;
      step_timeout_q <= step_timeout_d;
      fail_count_q   <= fail_count_d;
      done_q         <= done_d;
`ifdef Q_SWEEP_LOG_EN
      log_valid_q    <= log_valid_d;
      log_cycles_q   <= log_cycles_d;
      log_idx_q      <= log_idx_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    timer_d        = timer_q;
    confirm_d      = confirm_q;
    q_desired_d    = q_desired_q;
    loop_rst_d     = loop_rst_q;
    loop_start_d   = loop_start_q;
    loop_enable_d  = loop_enable_q;
    busy_d         = busy_q;
    step_idx_d     = step_idx_q;
    fail_count_d   = fail_count_q;
    step_ok_d      = 1'b0;
    step_timeout_d = 1'b0;
    done_d         = 1'b0;
`ifdef Q_SWEEP_LOG_EN
    log_valid_d    = 1'b0;
    log_cycles_d   = '0;
    log_idx_d      = '0;
`endif

    if ((state_q != S_IDLE) && abort) begin
      // Index and fail count stay frozen so the host can inspect them.
      state_d       = S_IDLE;
      busy_d        = 1'b0;
      loop_start_d  = 1'b0;
      loop_enable_d = 1'b0;
      loop_rst_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go && !abort) begin
            state_d      = S_INIT_RST;
            rst_cnt_d    = '0;
            step_idx_d   = '0;
            fail_count_d = '0;
            busy_d       = 1'b1;
            loop_rst_d   = 1'b1;
          end
        end
        S_INIT_RST: begin
          if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
            state_d    = S_ARM;
            rst_cnt_d  = '0;
            loop_rst_d = 1'b0;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        S_ARM: begin
          q_desired_d   = sp_table_q[step_idx_q];
          loop_start_d  = 1'b1;
          loop_enable_d = 1'b1;
          timer_d       = '0;
          confirm_d     = '0;
          state_d       = S_TRACK;
        end
        S_TRACK: begin
          timer_d   = timer_q + TW'(1);
          confirm_d = converged ? (confirm_q + CW'(1)) : '0;
          // Confirmation is tested first so it wins over a same-cycle timeout.
          if (confirm_d == CW'(CONFIRM_CYCLES)) begin
            step_ok_d  = 1'b1;
            state_d    = S_STEP_RST;
            rst_cnt_d  = '0;
            loop_rst_d = 1'b1;
`ifdef Q_SWEEP_LOG_EN
            log_valid_d  = 1'b1;
            log_cycles_d = timer_d;
            log_idx_d    = step_idx_q;
`endif
          end else if (timer_d == TW'(MAX_TIMEOUT)) begin
            step_timeout_d = 1'b1;
            if (fail_count_q != {FW{1'b1}}) begin
              fail_count_d = fail_count_q + FW'(1);
            end
            state_d    = S_STEP_RST;
            rst_cnt_d  = '0;
            loop_rst_d = 1'b1;
`ifdef Q_SWEEP_LOG_EN
            log_valid_d  = 1'b1;
            log_cycles_d = timer_d;
            log_idx_d    = step_idx_q;
`endif
          end
        end
        S_STEP_RST: begin
          if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
            rst_cnt_d  = '0;
            loop_rst_d = 1'b0;
            if (step_idx_q == IW'(N_SETPOINTS - 1)) begin
              state_d       = S_DONE;
              done_d        = 1'b1;
              busy_d        = 1'b0;
              loop_start_d  = 1'b0;
              loop_enable_d = 1'b0;
            end else begin
              step_idx_d = step_idx_q + IW'(1);
              state_d    = S_ARM;
            end
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign q_desired    = q_desired_q;
  assign loop_rst     = loop_rst_q;
  assign loop_start   = loop_start_q;
  assign loop_enable  = loop_enable_q;
  assign busy         = busy_q;
  assign step_idx     = step_idx_q;
  assign step_ok      = step_ok_q;
  assign step_timeout = step_timeout_q;
  assign fail_count   = fail_count_q;
  assign done         = done_q;
`ifdef Q_SWEEP_LOG_EN
  assign log_valid    = log_valid_q;
  assign log_cycles   = log_cycles_q;
  assign log_idx      = log_idx_q;
`endif

endmodule

// File: tb/tb_q_sweep_sequencer.sv
// Bench for q_sweep_sequencer: a behavioural model predicts every output each
// cycle, plus directed sweeps with hand-computed cycle counts and values.
module tb_q_sweep_sequencer;

  localparam int unsigned BW   = 10;
  localparam int unsigned N    = 4;
  localparam int unsigned TMO  = 20;
  localparam int unsigned RSTC = 5;
  localparam int unsigned CONF = 3;
  localparam int unsigned IW   = 2;
  localparam int unsigned TW   = 5;
  localparam int          FMAX = 7;

  localparam int P_IDLE = 0, P_INIT = 1, P_ARM = 2, P_TRACK = 3, P_STEPRST = 4, P_DONE = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          sp_wr_en = 1'b0;
  logic [IW-1:0] sp_wr_addr = '0;
  logic [BW-1:0] sp_wr_data = '0;
  logic          converged = 1'b0;
  logic [BW-1:0] q_desired;
  logic          loop_rst, loop_start, loop_enable, busy, step_ok, step_timeout, done;
  logic [IW-1:0] step_idx;
  logic [IW:0]   fail_count;
`ifdef Q_SWEEP_LOG_EN
  logic          log_valid;
  logic [TW-1:0] log_cycles;
  logic [IW-1:0] log_idx;
`endif

  q_sweep_sequencer #(
    .BUS_WIDTH(BW), .N_SETPOINTS(N), .MAX_TIMEOUT(TMO),
    .RST_CYCLES(RSTC), .CONFIRM_CYCLES(CONF)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .sp_wr_en(sp_wr_en), .sp_wr_addr(sp_wr_addr), .sp_wr_data(sp_wr_data),
    .converged(converged), .q_desired(q_desired), .loop_rst(loop_rst),
    .loop_start(loop_start), .loop_enable(loop_enable), .busy(busy),
    .step_idx(step_idx), .step_ok(step_ok), .step_timeout(step_timeout),
    .fail_count(fail_count),
`ifdef Q_SWEEP_LOG_EN
    .log_valid(log_valid), .log_cycles(log_cycles), .log_idx(log_idx),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired before the expected event", name);
  endtask

  // ---------------- behavioural model ----------------
  int            m_ph;
  int            m_cnt;
  int            m_hist[$];
  logic [BW-1:0] m_tbl [N];
  logic [BW-1:0] m_q;
  bit            m_lrst, m_start, m_en, m_busy, m_ok, m_to, m_done, m_logv;
  int            m_idx, m_fail, m_logc, m_logi;

  task automatic m_reset();
    m_ph = P_IDLE; m_cnt = 0; m_hist.delete();
    for (int i = 0; i < int'(N); i++) m_tbl[i] = '0;
    m_q = '0; m_lrst = 0; m_start = 0; m_en = 0; m_busy = 0;
    m_ok = 0; m_to = 0; m_done = 0; m_logv = 0;
    m_idx = 0; m_fail = 0; m_logc = 0; m_logi = 0;
  endtask

  // True when the last CONF samples of this step were all high.
  function automatic bit confirmed();
    if (m_hist.size() < int'(CONF)) return 0;
    for (int i = m_hist.size() - int'(CONF); i < m_hist.size(); i++)
      if (m_hist[i] == 0) return 0;
    return 1;
  endfunction

  task automatic end_track();
    m_logv = 1; m_logc = m_hist.size(); m_logi = m_idx;
    m_ph = P_STEPRST; m_cnt = 0; m_lrst = 1;
  endtask

  task automatic m_step();
    bit was_idle;
    was_idle = (m_ph == P_IDLE);
    m_ok = 0; m_to = 0; m_done = 0; m_logv = 0; m_logc = 0; m_logi = 0;
    if (sp_wr_en && !m_busy && was_idle && int'(sp_wr_addr) < int'(N))
      m_tbl[sp_wr_addr] = sp_wr_data;
    if (!was_idle && abort) begin
      m_ph = P_IDLE; m_busy = 0; m_start = 0; m_en = 0; m_lrst = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (go && !abort) begin
          m_ph = P_INIT; m_cnt = 0; m_idx = 0; m_fail = 0; m_busy = 1; m_lrst = 1;
        end
        P_INIT: begin
          m_cnt++;
          if (m_cnt == int'(RSTC)) begin m_ph = P_ARM; m_lrst = 0; end
        end
        P_ARM: begin
          m_q = m_tbl[m_idx]; m_start = 1; m_en = 1; m_hist.delete(); m_ph = P_TRACK;
        end
        P_TRACK: begin
          m_hist.push_back(int'(converged));
          if (confirmed()) begin
            m_ok = 1; end_track();
          end else if (m_hist.size() == int'(TMO)) begin
            m_to = 1;
            if (m_fail < FMAX) m_fail++;
            end_track();
          end
        end
        P_STEPRST: begin
          m_cnt++;
          if (m_cnt == int'(RSTC)) begin
            m_lrst = 0;
            if (m_idx == int'(N) - 1) begin
              m_ph = P_DONE; m_done = 1; m_busy = 0; m_start = 0; m_en = 0;
            end else begin
              m_idx++; m_ph = P_ARM;
            end
          end
        end
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  always @(negedge rst) m_reset();
  always @(posedge clk) if (rst) m_step();

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("q_desired", q_desired, m_q);
      chk("loop_rst", loop_rst, m_lrst);
      chk("loop_start", loop_start, m_start);
      chk("loop_enable", loop_enable, m_en);
      chk("busy", busy, m_busy);
      chk("step_idx", step_idx, m_idx);
      chk("step_ok", step_ok, m_ok);
      chk("step_timeout", step_timeout, m_to);
      chk("fail_count", fail_count, m_fail);
      chk("done", done, m_done);
`ifdef Q_SWEEP_LOG_EN
      chk("log_valid", log_valid, m_logv);
      chk("log_cycles", log_cycles, m_logc);
      chk("log_idx", log_idx, m_logi);
`endif
    end
  end

  // ---------------- observation counters ----------------
  int            obs_ok = 0, obs_to = 0, obs_done = 0;
  logic [BW-1:0] obs_q[$];
  logic [BW-1:0] last_q = '0;
  always @(negedge clk) begin
    if (step_ok === 1'b1) obs_ok++;
    if (step_timeout === 1'b1) obs_to++;
    if (done === 1'b1) obs_done++;
    if (q_desired !== last_q) begin obs_q.push_back(q_desired); last_q = q_desired; end
  end

  // ---------------- converged driver ----------------
  int conv_mode = 0;
  int pat[6] = '{1, 1, 0, 1, 1, 1};
  always @(negedge clk) begin
    int k;
    k = m_hist.size();
    case (conv_mode)
      1: converged = (m_ph == P_TRACK) && (k >= 10);
      2: converged = (m_ph == P_TRACK && k < 6) ? (pat[k] != 0) : 1'b1;
      3: converged = ($urandom_range(0, 9) < 4);
      4: converged = (m_ph == P_TRACK) && (k >= 6);
      default: converged = 1'b0;
    endcase
  end

  // Start a sweep and count rising edges from the go sample to the done cycle.
  task automatic sweep(output int n);
    go = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    go = 1'b0;
    while (done !== 1'b1 && n < 500) begin
      @(posedge clk); n++; @(negedge clk);
    end
    if (done !== 1'b1) expire("sweep_done");
  endtask

  task automatic wait_track(input string name);
    int t = 0;
    while (m_ph != P_TRACK && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) expire(name);
  endtask

  task automatic clear_obs();
    obs_ok = 0; obs_to = 0; obs_done = 0; obs_q.delete();
  endtask

  initial begin
    int n;
    int t;
    m_reset();
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("reset_busy", busy, 0);
    chk("reset_q_desired", q_desired, 0);
    chk("reset_loop_rst", loop_rst, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < int'(N); i++) begin
      sp_wr_en = 1'b1; sp_wr_addr = IW'(i); sp_wr_data = BW'(40 + 20 * i);
      @(negedge clk);
    end
    sp_wr_en = 1'b0;

    // Normal sweep: converged rises after 10 TRACK cycles.
    conv_mode = 1; clear_obs();
    sweep(n);
    chk("t1_sweep_cycles", n, 81);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_ok_count", obs_ok, 4);
    chk("t1_timeouts", obs_to, 0);
    chk("t1_done_count", obs_done, 1);
    chk("t1_fail_count", fail_count, 0);
    chk("t1_q_steps", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("t1_q0", obs_q[0], 40);
      chk("t1_q1", obs_q[1], 60);
      chk("t1_q2", obs_q[2], 80);
      chk("t1_q3", obs_q[3], 100);
    end

    // Every step times out after TMO TRACK cycles.
    conv_mode = 0; clear_obs();
    sweep(n);
    chk("t2_sweep_cycles", n, 109);
    @(negedge clk);
    chk("t2_timeouts", obs_to, 4);
    chk("t2_ok_count", obs_ok, 0);
    chk("t2_fail_count", fail_count, 4);
    chk("t2_done_count", obs_done, 1);

    // Glitchy convergence; held high through STEP_RST.
    conv_mode = 2; clear_obs();
    sweep(n);
    chk("t3_sweep_cycles", n, 53);
    @(negedge clk);
    chk("t3_ok_count", obs_ok, 4);
    chk("t3_timeouts", obs_to, 0);

    // Abort in TRACK of step 2, then restart.
    conv_mode = 0; clear_obs();
    go = 1'b1; @(negedge clk); go = 1'b0;
    t = 0;
    while (!(m_ph == P_TRACK && m_idx == 2 && m_hist.size() == 3) && t < 300) begin
      @(negedge clk); t++;
    end
    if (t >= 300) expire("t4_reach_step2");
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_loop_enable", loop_enable, 0);
    chk("t4_step_idx", step_idx, 2);
    chk("t4_fail_count", fail_count, 2);
    repeat (30) @(negedge clk);
    chk("t4_no_done", obs_done, 0);
    go = 1'b1; @(negedge clk); go = 1'b0;
    chk("t4_restart_idx", step_idx, 0);
    chk("t4_restart_fail", fail_count, 0);
    chk("t4_restart_busy", busy, 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;

    // Table write during a sweep is ignored; async reset mid STEP_RST.
    conv_mode = 1;
    go = 1'b1; @(negedge clk); go = 1'b0;
    repeat (3) @(negedge clk);
    sp_wr_en = 1'b1; sp_wr_addr = '0; sp_wr_data = BW'(999);
    @(negedge clk);
    sp_wr_en = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) expire("t5_first_done");
    @(negedge clk);
    go = 1'b1; @(negedge clk); go = 1'b0;
    wait_track("t5_track");
    chk("t5_table_kept", q_desired, 40);
    t = 0;
    while (!(m_ph == P_STEPRST && m_cnt == 2) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) expire("t5_reach_steprst");
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_q", q_desired, 0);
    chk("t5_rst_loop_rst", loop_rst, 0);
    chk("t5_rst_enable", loop_enable, 0);
    chk("t5_rst_start", loop_start, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ok", step_ok, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    go = 1'b1; @(negedge clk); go = 1'b0;
    wait_track("t5_track_after_rst");
    chk("t5_table_cleared", q_desired, 0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;

`ifdef Q_SWEEP_LOG_EN
    // Convergence from TRACK cycle 7 confirms on cycle 9.
    conv_mode = 4;
    go = 1'b1; @(negedge clk); go = 1'b0;
    t = 0;
    while (log_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) expire("t6_log_valid");
    chk("t6_log_cycles", log_cycles, 9);
    chk("t6_log_idx", log_idx, 0);
    chk("t6_step_ok", step_ok, 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
`endif

    // Randomized traffic against the model.
    conv_mode = 3;
    for (int c = 0; c < 3000; c++) begin
      go = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 149) == 0);
      sp_wr_en = ($urandom_range(0, 9) == 0);
      sp_wr_addr = IW'($urandom_range(0, 3));
      sp_wr_data = BW'($urandom);
      @(negedge clk);
    end
    go = 1'b0; abort = 1'b0; sp_wr_en = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
